// File: rtl/cache_nway_pkg.sv
// Shared LC-3b memory-hierarchy types for the N-way cache: bus widths,
// controller states and the byte-merge helper used on write hits.
package cache_nway_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] mem_bus;
    typedef logic [1:0]   lc3b_mem_wmask;

    localparam int LC3B_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    function automatic lc3b_word merge_word(
        input lc3b_word      old_word,
        input lc3b_word      new_word,
        input lc3b_mem_wmask byte_en
    );
        lc3b_word merged;
        merged = old_word;
        if (byte_en[0]) merged[7:0]  = new_word[7:0];
        if (byte_en[1]) merged[15:8] = new_word[15:8];
        return merged;
    endfunction

endpackage

// File: rtl/cache_nway_if.sv
// CPU-side word port and memory-side line port of the cache bundled together;
// the cache uses the slave view, the surrounding system the master view.
interface cache_nway_if;
    import cache_nway_pkg::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    mem_bus        pmem_wdata;
    mem_bus        pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_nway_plru_tree.sv
// Tree pseudo-LRU for one set: node n lives at tree_bits[n-1] (heap order,
// root = 1); a bit value of 1 means the victim lies in the right subtree.
module plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         tree_bits,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-2:0]         tree_next
);
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0][WAY_BITS-1:0] path_match;
    logic [NUM_WAYS-1:0]               victim_onehot;

    // A leaf is the victim when every ancestor bit steers toward it.
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_leaf
        for (genvar gl = 0; gl < WAY_BITS; gl++) begin : g_lvl
            localparam int   NODE = (NUM_WAYS + gi) >> (WAY_BITS - gl);
            localparam logic DIR  = 1'((gi >> (WAY_BITS - 1 - gl)) & 1);
            assign path_match[gi][gl] = (tree_bits[NODE-1] == DIR);
        end
        assign victim_onehot[gi] = &path_match[gi];
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (victim_onehot[w]) victim_way = WAY_BITS'(w);
        end
    end

    // Nodes on the accessed way's path flip to point at the other subtree.
    for (genvar gi = 1; gi < NUM_WAYS; gi++) begin : g_node
        localparam int               LVL     = $clog2(gi + 1) - 1;
        localparam logic [WAY_BITS:0] NODE_ID = (WAY_BITS + 1)'(gi);
        assign tree_next[gi-1] =
            (({1'b1, access_way} >> (WAY_BITS - LVL)) == NODE_ID)
                ? ~access_way[WAY_BITS-1-LVL]
                : tree_bits[gi-1];
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU.
// Optional saturating hit/miss counters are built when CACHE_PERF_CTR_EN is defined.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    cache_nway_if.slave  bus,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int OFF_BITS = LC3B_LINE_OFFSET_BITS;
    localparam int TAG_BITS = 16 - OFF_BITS - IDX_BITS;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_reg;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_reg;
    logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru_reg;
    logic [TAG_BITS-1:0]               tag_mem  [NUM_SETS][NUM_WAYS];
    mem_bus                            data_mem [NUM_SETS][NUM_WAYS];

    cache_state_t        state_reg;
    logic [WAY_BITS-1:0] victim_reg;
    logic [IDX_BITS-1:0] miss_idx_reg;
    logic [TAG_BITS-1:0] miss_tag_reg;

    logic                req;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [2:0]          word_sel;
    logic                unused_addr_bit;

    assign req             = bus.mem_read | bus.mem_write;
    assign req_idx         = bus.mem_address[OFF_BITS +: IDX_BITS];
    assign req_tag         = bus.mem_address[15 -: TAG_BITS];
    assign word_sel        = bus.mem_address[3:1];
    assign unused_addr_bit = bus.mem_address[0];

    // Tag compare across all ways of the indexed set.
    logic [NUM_WAYS-1:0] way_hit;
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign way_hit[gi] = valid_reg[req_idx][gi] && (tag_mem[req_idx][gi] == req_tag);
    end

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    mem_bus              hit_line;
    lc3b_word            hit_word;
    mem_bus              hit_line_merged;

    assign hit = (state_reg == IDLE) && req && (|way_hit);

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_BITS'(w);
        end
    end

    assign hit_line = data_mem[req_idx][hit_way];
    assign hit_word = hit_line[{word_sel, 4'h0} +: 16];

    always_comb begin
        hit_line_merged = hit_line;
        hit_line_merged[{word_sel, 4'h0} +: 16] =
            merge_word(hit_word, bus.mem_wdata, bus.mem_byte_enable);
    end

    assign bus.mem_resp  = hit;
    assign bus.mem_rdata = hit ? hit_word : 16'h0000;

    // Victim choice: lowest invalid way wins over the PLRU suggestion.
    logic                has_invalid;
    logic [WAY_BITS-1:0] invalid_way;
    logic [WAY_BITS-1:0] plru_victim;
    logic [NUM_WAYS-2:0] plru_next;
    logic [WAY_BITS-1:0] miss_victim;
    logic                victim_dirty;

    always_comb begin
        has_invalid = 1'b0;
        invalid_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[req_idx][w]) begin
                has_invalid = 1'b1;
                invalid_way = WAY_BITS'(w);
            end
        end
    end

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .tree_bits  (plru_reg[req_idx]),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .tree_next  (plru_next)
    );

    assign miss_victim  = has_invalid ? invalid_way : plru_victim;
    assign victim_dirty = valid_reg[req_idx][miss_victim] && dirty_reg[req_idx][miss_victim];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            valid_reg    <= '0;
            dirty_reg    <= '0;
            plru_reg     <= '0;
            victim_reg   <= '0;
            miss_idx_reg <= '0;
            miss_tag_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        plru_reg[req_idx] <= plru_next;
                        if (bus.mem_write) dirty_reg[req_idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_reg   <= miss_victim;
                        miss_idx_reg <= req_idx;
                        miss_tag_reg <= req_tag;
                        state_reg    <= victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) state_reg <= FILL;
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid_reg[miss_idx_reg][victim_reg] <= 1'b1;
                        dirty_reg[miss_idx_reg][victim_reg] <= 1'b0;
                        state_reg                           <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (state_reg == FILL && bus.pmem_resp) begin
            data_mem[miss_idx_reg][victim_reg] <= bus.pmem_rdata;
            tag_mem[miss_idx_reg][victim_reg]  <= miss_tag_reg;
        end else if (hit && bus.mem_write) begin
            data_mem[req_idx][hit_way] <= hit_line_merged;
        end
    end

    // Memory-side outputs derive from the reset-cleared state, so rst drops them at once.
    always_comb begin
        bus.pmem_read    = (state_reg == FILL);
        bus.pmem_write   = (state_reg == WRITEBACK);
        bus.pmem_address = 16'h0000;
        bus.pmem_wdata   = '0;
        case (state_reg)
            WRITEBACK: begin
                bus.pmem_address = {tag_mem[miss_idx_reg][victim_reg], miss_idx_reg, 4'h0};
                bus.pmem_wdata   = data_mem[miss_idx_reg][victim_reg];
            end
            FILL: begin
                bus.pmem_address = {miss_tag_reg, miss_idx_reg, 4'h0};
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CTR_EN
    logic [15:0] hit_count_reg;
    logic [15:0] miss_count_reg;
    logic        miss_start;

    assign miss_start = (state_reg == IDLE) && req && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_reg  <= 16'h0000;
            miss_count_reg <= 16'h0000;
        end else begin
            if (hit && hit_count_reg != 16'hFFFF)
                hit_count_reg <= hit_count_reg + 16'h0001;
            if (miss_start && miss_count_reg != 16'hFFFF)
                miss_count_reg <= miss_count_reg + 16'h0001;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed vector table, multi-cycle corner
// sequences and a randomized run against a flat word-memory reference.
module tb_cache_nway;
    import cache_nway_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    cache_nway_if bus ();

    cache_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int tests = 0;
    int fails = 0;

    // Physical memory contents and the CPU-visible memory image.
    logic [15:0] pmem_words [32768];
    logic [15:0] ref_words  [32768];

    int          pmem_delay = 0;
    int          wait_cnt   = 0;
    bit          active     = 0;
    logic [15:0] act_addr;
    bit          act_rd, act_wr;
    mem_bus      act_wdata;
    int          viol_cnt   = 0;
    int          n_reads    = 0;
    int          n_writes   = 0;
    bit          log_wr   [$];
    logic [15:0] log_addr [$];
    mem_bus      log_data [$];

    function automatic logic [15:0] init_word(input int w);
        int v;
        v = w * 40503 + 12345;
        return v[15:0];
    endfunction

    function automatic mem_bus pm_line(input logic [15:0] a);
        mem_bus l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = pmem_words[{a[15:4], 3'(k)}];
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Physical memory responder: fixed extra delay, stability and exclusivity watch.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.pmem_resp = 1'b0;
                active        = 0;
                wait_cnt      = 0;
            end else if (bus.pmem_resp) begin
                if (act_wr)
                    for (int k = 0; k < 8; k++)
                        pmem_words[{act_addr[15:4], 3'(k)}] = act_wdata[16*k +: 16];
                bus.pmem_resp = 1'b0;
                active        = 0;
                wait_cnt      = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (bus.pmem_read && bus.pmem_write) viol_cnt++;
                if (!active) begin
                    active    = 1;
                    act_addr  = bus.pmem_address;
                    act_rd    = bus.pmem_read;
                    act_wr    = bus.pmem_write;
                    act_wdata = bus.pmem_wdata;
                    log_wr.push_back(act_wr);
                    log_addr.push_back(act_addr);
                    log_data.push_back(act_wdata);
                    if (act_wr) n_writes++; else n_reads++;
                end else if (bus.pmem_address != act_addr || bus.pmem_read != act_rd ||
                             bus.pmem_write != act_wr || (act_wr && bus.pmem_wdata != act_wdata)) begin
                    viol_cnt++;
                end
                if (wait_cnt >= pmem_delay) begin
                    bus.pmem_rdata = pm_line(act_addr);
                    bus.pmem_resp  = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                active   = 0;
                wait_cnt = 0;
            end
        end
    end

    task automatic sync_ref();
        for (int w = 0; w < 32768; w++) ref_words[w] = pmem_words[w];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sync_ref();
    endtask

    task automatic cpu_req(input bit wr, input bit rd_also, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be,
                           output logic [15:0] rd, output int lat, output bit ok);
        @(negedge clk);
        bus.mem_read        = !wr || rd_also;
        bus.mem_write       = wr;
        bus.mem_address     = a;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        #1;
        lat = 0;
        while (!bus.mem_resp && lat < 200) begin
            @(negedge clk); #1;
            lat++;
        end
        ok = bus.mem_resp;
        rd = bus.mem_rdata;
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (ok && wr) ref_words[a[15:1]] = merge_word(ref_words[a[15:1]], wd, be);
        $display("[TB] txn wr=%0d addr=%h wdata=%h be=%b rdata=%h lat=%0d resp=%0d",
                 wr, a, wd, be, rd, lat, ok);
    endtask

    typedef struct {
        bit          do_rst;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        bit          chk_rd;
        logic [15:0] exp_rd;
        int          exp_reads;
        int          exp_writes;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          lat;
        bit          ok;
        int          r0, w0;
        bit          saw_wb;
        logic [15:0] exp_hc, exp_mc;

        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0000;
        bus.mem_wdata       = 16'h0000;
        bus.mem_byte_enable = 2'b00;
        rst                 = 1'b1;

        for (int w = 0; w < 32768; w++) pmem_words[w] = init_word(w);
        pmem_words[15'h091A] = 16'hBEEF;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'hBEEF,             1, 0};
        vecs[1] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'hBEEF,             0, 0};
        vecs[2] = '{1'b0, 1'b1, 16'h1234, 16'hABCD, 2'b01, 1'b0, 16'h0000,             0, 0};
        vecs[3] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'hBECD,             0, 0};
        vecs[4] = '{1'b1, 1'b1, 16'h0030, 16'h1111, 2'b11, 1'b0, 16'h0000,             1, 0};
        vecs[5] = '{1'b0, 1'b0, 16'h00B0, 16'h0000, 2'b00, 1'b1, init_word('h00B0/2),  1, 0};
        vecs[6] = '{1'b0, 1'b0, 16'h0130, 16'h0000, 2'b00, 1'b1, init_word('h0130/2),  1, 0};
        vecs[7] = '{1'b0, 1'b0, 16'h01B0, 16'h0000, 2'b00, 1'b1, init_word('h01B0/2),  1, 0};
        vecs[8] = '{1'b0, 1'b0, 16'h0230, 16'h0000, 2'b00, 1'b1, init_word('h0230/2),  1, 1};
        vecs[9] = '{1'b0, 1'b0, 16'h00B0, 16'h0000, 2'b00, 1'b1, init_word('h00B0/2),  0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_resp",     {31'd0, bus.mem_resp},   32'd0);
        check("rst_pmem_read",    {31'd0, bus.pmem_read},  32'd0);
        check("rst_pmem_write",   {31'd0, bus.pmem_write}, 32'd0);
        check("rst_pmem_address", {16'd0, bus.pmem_address}, 32'd0);
        check("rst_mem_rdata",    {16'd0, bus.mem_rdata},  32'd0);
        check("rst_hit_count",    {16'd0, hit_count},      32'd0);
        check("rst_miss_count",   {16'd0, miss_count},     32'd0);
        rst = 1'b0;
        sync_ref();

`ifdef CACHE_PERF_CTR_EN
        exp_hc = 16'd2;
        exp_mc = 16'd1;
`else
        exp_hc = 16'd0;
        exp_mc = 16'd0;
`endif

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_rst) apply_reset();
            r0 = n_reads;
            w0 = n_writes;
            log_wr.delete();
            log_addr.delete();
            log_data.delete();
            cpu_req(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat, ok);
            check($sformatf("vec%0d_resp", i), {31'd0, ok}, 32'd1);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_pmem_reads", i),  n_reads - r0,  vecs[i].exp_reads);
            check($sformatf("vec%0d_pmem_writes", i), n_writes - w0, vecs[i].exp_writes);
            if (i == 0) begin
                check("cold_fill_addr", {16'd0, log_addr[0]}, 32'h1230);
                check("cold_latency", lat, 2);
            end
            if (i == 1) begin
                check("repeat_hit_latency", lat, 0);
                check("hit_count", {16'd0, hit_count},  {16'd0, exp_hc});
                check("miss_count", {16'd0, miss_count}, {16'd0, exp_mc});
            end
            if (i == 8) begin
                check("evict_log_len", log_wr.size(), 2);
                check("evict_wb_first", {31'd0, log_wr[0]}, 32'd1);
                check("evict_wb_addr", {16'd0, log_addr[0]}, 32'h0030);
                check("evict_wb_data", {16'd0, log_data[0][15:0]}, 32'h1111);
                check("evict_fill_addr", {16'd0, log_addr[1]}, 32'h0230);
            end
        end

        // Slow memory: ten extra cycles of pmem_resp delay
        pmem_delay = 10;
        r0 = n_reads;
        cpu_req(1'b0, 1'b0, 16'h4000, 16'h0000, 2'b00, rd, lat, ok);
        check("slow_resp", {31'd0, ok}, 32'd1);
        check("slow_latency", lat, 12);
        check("slow_rdata", {16'd0, rd}, {16'd0, init_word('h4000/2)});
        check("slow_reads", n_reads - r0, 1);
        check("slow_stable", viol_cnt, 0);
        pmem_delay = 0;

        // Reset asserted during a writeback
        apply_reset();
        cpu_req(1'b1, 1'b0, 16'h0050, 16'h5050, 2'b11, rd, lat, ok);
        cpu_req(1'b1, 1'b0, 16'h00D0, 16'hD0D0, 2'b11, rd, lat, ok);
        cpu_req(1'b1, 1'b0, 16'h0150, 16'h5151, 2'b11, rd, lat, ok);
        cpu_req(1'b1, 1'b0, 16'h01D0, 16'hD1D1, 2'b11, rd, lat, ok);
        pmem_delay = 10;
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0250;
        saw_wb = 0;
        for (int c = 0; c < 20 && !saw_wb; c++) begin
            @(negedge clk);
            saw_wb = bus.pmem_write;
        end
        check("rstwb_seen", {31'd0, saw_wb}, 32'd1);
        check("rstwb_addr", {16'd0, bus.pmem_address}, 32'h0050);
        check("rstwb_rdata_zero", {16'd0, bus.mem_rdata}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rstwb_pmem_write_drop", {31'd0, bus.pmem_write}, 32'd0);
        check("rstwb_pmem_read_low",   {31'd0, bus.pmem_read},  32'd0);
        @(negedge clk);
        bus.mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sync_ref();
        pmem_delay = 0;
        r0 = n_reads;
        cpu_req(1'b0, 1'b0, 16'h00D0, 16'h0000, 2'b00, rd, lat, ok);
        check("post_rst_miss", n_reads - r0, 1);
        check("post_rst_rdata", {16'd0, rd}, {16'd0, ref_words[15'h0068]});

        // Randomized traffic against the flat memory image
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            logic [15:0] wd;
            logic [15:0] exp;
            bit          wr, both;
            pmem_delay = $urandom_range(0, 3);
            a    = {9'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            wd   = 16'($urandom);
            wr   = ($urandom_range(0, 2) == 0);
            both = wr && ($urandom_range(0, 3) == 0);
            exp  = ref_words[a[15:1]];
            cpu_req(wr, both, a, wd, 2'($urandom_range(0, 3)), rd, lat, ok);
            check($sformatf("rand%0d_resp", n), {31'd0, ok}, 32'd1);
            if (!wr) check($sformatf("rand%0d_rdata@%h", n, a), {16'd0, rd}, {16'd0, exp});
        end

        check("pmem_protocol", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
